dds_phase_reader: RTL and testbench
===================================

// Module: dds_phase_reader
// PURPOSE
//   Read side of the reprogrammable quarter-wave LUT. Runs a phase accumulator,
//   turns phase into LUT read strobes and addresses (with quarter-wave mirroring),
//   and rebuilds a full-period offset-binary sine sample from each returned magnitude.
//   It sits between the tuning-word inputs and the lut_rw read port. Its sample output
//   feeds the DAC/output pins.
// PARAMETERS
//   PW  16  phase accumulator width (bits); must be >= AW+2
//   AW  4   LUT address width; table depth = 2**AW entries per quarter wave
//   WW  6   LUT word width = unsigned magnitude width
// PORTS
//   clk          in   1      clock; all state updates on rising edge
//   rst          in   1      reset, synchronous, active-high
//   en           in   1      1 = advance phase and issue one LUT read this edge
//   phase_clr    in   1      1 = force phase to 0 and flush in-flight reads
//   ftw_we       in   1      1 = load ftw_in into the tuning-word register
//   ftw_in       in   PW     frequency tuning word (phase increment)
//   lut_re       out  1      LUT read enable (registered)
//   lut_ra       out  AW     LUT read address (registered)
//   lut_rd       in   WW     LUT read data; valid 1 edge after lut_re is sampled
//   sample_out   out  WW+1   offset-binary sine sample (registered)
//   sample_valid out  1      1-cycle strobe: sample_out updated this cycle
// BEHAVIOUR
//   Reset (rst=1 at edge): phase=0, ftw=0, lut_re=0, lut_ra=0, pipeline valids=0,
//     sample_valid=0, sample_out=2**WW (midscale, 64 at WW=6).
//   Phase decode: q = phase[PW-1:PW-2]; idx = phase[PW-3:PW-2-AW].
//     lut_ra = q[0] ? ~idx : idx   (mirror in quadrants 1 and 3)
//     sign = q[1]   (negative half in quadrants 2 and 3)
//   Stage 0, edge E with en=1, phase_clr=0:
//     lut_re<=1; lut_ra<=decode(phase); sign pipelined; phase<=phase+ftw (mod 2**PW).
//     en=0 at E: lut_re<=0, phase holds.
//   Stage 1, edge E+1: the LUT registers lut_rd; sign and valid advance one stage.
//   Stage 2, edge E+2: sample_out<= sign ? (2**WW-1-lut_rd) : (2**WW+lut_rd);
//     sample_valid<=1. Without a valid sample at this stage: sample_valid<=0 and
//     sample_out holds.
//   Latency: 2 edges from lut_re assertion to sample_valid. Throughput: one sample
//     per clock while en=1, with no bubbles.
//   ftw_we: ftw<=ftw_in at the edge. The accumulate at that same edge uses the
//     old ftw; the new value applies from the next edge.
//   phase_clr (priority over en): phase<=0, lut_re<=0, all pipeline valids cleared.
//     In-flight samples are dropped (no sample_valid for them) and sample_out holds.
//     ftw_we in the same cycle is still honoured.
//   Reset has priority over everything, including mid-pipeline; in-flight reads
//     are discarded.
//   Wrap: phase wraps silently at 2**PW. ftw=0 with en=1 repeats the same address.
//   Output range at WW=6: 0..127, continuous across the quadrant boundaries (63|64).
// TESTING  (PW=16, AW=4, WW=6, LUT model 1-cycle latency, LUT[i]=4*i)
//   T1 reset: hold rst 2 edges -> lut_re=0, sample_valid=0, sample_out=64.
//   T2 ftw=1024, en=1 continuous -> lut_ra sequence 0,1..15,15,14..0,0,1..;
//      samples 64,68..124,124..64,63,59..3,3..63; period of 64; valid every cycle.
//   T3 ftw_we with ftw_in=2048 mid-run, in the same cycle as en -> that step is
//      still +1024, every following step is +2048.
//   T4 phase_clr while 2 reads are in flight -> next 2 cycles sample_valid=0 and
//      sample_out holds; next read is ra=0 -> sample 64.
//   T5 en toggled 1,0,1 -> exactly 2 sample_valid pulses, each 2 edges after its
//      lut_re; phase advanced exactly twice.
//   T6 ftw=65535, 3 steps -> phase 65535, 65534, 65533 (wrap);
//      ra = ~15 -> 0 (quadrant 3, mirrored); sample 63.

Source files
------------

// File: rtl/dds_phase_reader.sv
// Read side of the quarter-wave sine LUT: a phase accumulator drives mirrored LUT reads,
// and each returned magnitude is rebuilt into a full-period offset-binary sample.
module dds_phase_reader #(
  parameter int PW = 16,
  parameter int AW = 4,
  parameter int WW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          phase_clr,
  input  logic          ftw_we,
  input  logic [PW-1:0] ftw_in,
  output logic          lut_re,
  output logic [AW-1:0] lut_ra,
  input  logic [WW-1:0] lut_rd,
  output logic [WW:0]   sample_out,
  output logic          sample_valid
);

  logic [PW-1:0] phase_q, phase_d;
  logic [PW-1:0] ftw_q, ftw_d;
  logic          lut_re_q, lut_re_d;
  logic [AW-1:0] lut_ra_q, lut_ra_d;
  logic          sign0_q, sign0_d;
  logic          valid1_q, valid1_d;
  logic          sign1_q, sign1_d;
  logic [WW:0]   sample_q, sample_d;
  logic          sample_valid_q, sample_valid_d;

  logic [1:0]    quad;
  logic [AW-1:0] idx;

  assign quad = phase_q[PW-1:PW-2];
  assign idx  = phase_q[PW-3:PW-2-AW];

  always_comb begin
    phase_d        = phase_q;
    ftw_d          = ftw_q;
    lut_re_d       = 1'b0;
    lut_ra_d       = lut_ra_q;
    sign0_d        = sign0_q;
    valid1_d       = lut_re_q;
    sign1_d        = sign0_q;
    sample_d       = sample_q;
    sample_valid_d = valid1_q;

    if (ftw_we) ftw_d = ftw_in;

    // The clear drops every in-flight read, including the one about to emerge.
    if (phase_clr) begin
      phase_d        = '0;
      valid1_d       = 1'b0;
      sample_valid_d = 1'b0;
    end else begin
      if (en) begin
        lut_re_d = 1'b1;
        lut_ra_d = quad[0] ? ~idx : idx;
        sign0_d  = quad[1];
        phase_d  = phase_q + ftw_q;
      end
      if (valid1_q) begin
        sample_d = sign1_q ? {1'b0, ~lut_rd} : {1'b1, lut_rd};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q        <= '0;
      ftw_q          <= '0;
      lut_re_q       <= 1'b0;
      lut_ra_q       <= '0;
      sign0_q        <= 1'b0;
      valid1_q       <= 1'b0;
      sign1_q        <= 1'b0;
      sample_q       <= {1'b1, {WW{1'b0}}};
      sample_valid_q <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      ftw_q          <= ftw_d;
      lut_re_q       <= lut_re_d;
      lut_ra_q       <= lut_ra_d;
      sign0_q        <= sign0_d;
      valid1_q       <= valid1_d;
      sign1_q        <= sign1_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign lut_re       = lut_re_q;
  assign lut_ra       = lut_ra_q;
  assign sample_out   = sample_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_dds_phase_reader.sv
// Directed bench for dds_phase_reader with a 1-cycle LUT model holding LUT[i]=4*i.
module tb_dds_phase_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        phase_clr = 1'b0;
  logic        ftw_we = 1'b0;
  logic [15:0] ftw_in = '0;
  logic        lut_re;
  logic [3:0]  lut_ra;
  logic [5:0]  lut_rd = '0;
  logic [6:0]  sample_out;
  logic        sample_valid;

  int total = 0;
  int bad = 0;

  dds_phase_reader #(.PW(16), .AW(4), .WW(6)) dut (
    .clk(clk), .rst(rst), .en(en), .phase_clr(phase_clr), .ftw_we(ftw_we),
    .ftw_in(ftw_in), .lut_re(lut_re), .lut_ra(lut_ra), .lut_rd(lut_rd),
    .sample_out(sample_out), .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (lut_re) lut_rd <= {lut_ra, 2'b00};

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; phase_clr = 1'b0; ftw_we = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic load_ftw(input logic [15:0] v);
    ftw_we = 1'b1; ftw_in = v;
    step();
    ftw_we = 1'b0;
  endtask

  // Hand-derived quarter-wave walk for a tuning word of 1024 (one LUT index per step)
  function automatic int ra_1024(input int k);
    int m = k % 64;
    int q = m / 16;
    int i = m % 16;
    return (q % 2 == 1) ? 15 - i : i;
  endfunction

  function automatic int s_1024(input int k);
    int m = k % 64;
    return (m < 32) ? 64 + 4 * ra_1024(k) : 63 - 4 * ra_1024(k);
  endfunction

  int t3_ra[8] = '{0, 1, 2, 3, 4, 6, 8, 10};
  int t5_en[8] = '{1, 0, 1, 0, 0, 0, 1, 0};
  int t5_re[8] = '{1, 0, 1, 0, 0, 0, 1, 0};
  int t5_sv[8] = '{0, 0, 1, 0, 1, 0, 0, 0};
  int t5_ra[8] = '{0, 0, 1, 0, 0, 0, 2, 0};
  int t5_s[8]  = '{64, 64, 64, 64, 68, 68, 68, 68};

  initial begin
    int pulses;

    // T1 reset
    do_reset();
    chk("rst_re", lut_re, 0);
    chk("rst_sv", sample_valid, 0);
    chk("rst_so", sample_out, 64);
    chk("rst_ra", lut_ra, 0);

    // T2 ftw=1024 continuous
    load_ftw(16'd1024);
    en = 1'b1;
    for (int k = 0; k < 70; k++) begin
      step();
      chk("t2_re", lut_re, 1);
      chk("t2_ra", lut_ra, ra_1024(k));
      if (k >= 2) begin
        chk("t2_sv", sample_valid, 1);
        chk("t2_so", sample_out, s_1024(k - 2));
      end
    end
    en = 1'b0;

    // T3 tuning word change coinciding with a step
    do_reset();
    load_ftw(16'd1024);
    en = 1'b1;
    for (int j = 0; j < 8; j++) begin
      ftw_we = (j == 3);
      ftw_in = 16'd2048;
      step();
      chk("t3_ra", lut_ra, t3_ra[j]);
      if (j >= 2) chk("t3_so", sample_out, 64 + 4 * t3_ra[j - 2]);
    end
    ftw_we = 1'b0;

    // T4 clear with two reads in flight; last sample shown was from ra=6
    phase_clr = 1'b1;
    step();
    phase_clr = 1'b0;
    chk("t4_re_clr", lut_re, 0);
    chk("t4_sv_clr", sample_valid, 0);
    chk("t4_so_clr", sample_out, 88);
    step();
    chk("t4_re_a", lut_re, 1);
    chk("t4_ra_a", lut_ra, 0);
    chk("t4_sv_a", sample_valid, 0);
    chk("t4_so_a", sample_out, 88);
    step();
    chk("t4_ra_b", lut_ra, 2);
    chk("t4_sv_b", sample_valid, 0);
    step();
    chk("t4_sv_c", sample_valid, 1);
    chk("t4_so_c", sample_out, 64);
    en = 1'b0;

    // T5 en pattern 1,0,1 with a trailing read to confirm phase advanced twice
    do_reset();
    load_ftw(16'd1024);
    pulses = 0;
    for (int j = 0; j < 8; j++) begin
      en = t5_en[j][0];
      step();
      chk("t5_re", lut_re, t5_re[j]);
      chk("t5_sv", sample_valid, t5_sv[j]);
      chk("t5_so", sample_out, t5_s[j]);
      if (t5_re[j] == 1) chk("t5_ra", lut_ra, t5_ra[j]);
      if (j < 6 && sample_valid) pulses++;
    end
    chk("t5_pulses", pulses, 2);
    en = 1'b0;

    // T6 ftw=65535: phase walks 0,65535,65534,65533 (quadrant 3, mirrored to 0)
    do_reset();
    load_ftw(16'hFFFF);
    en = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step();
      chk("t6_ra", lut_ra, 0);
    end
    en = 1'b0;
    chk("t6_so0", sample_out, 63);
    step();
    chk("t6_sv", sample_valid, 1);
    chk("t6_so", sample_out, 63);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
